// File: rtl/br_writeback_pkg.sv
// Shared types for the register-bank writeback path.
// Request bundle reused by ALU and memory stages.
package br_writeback_pkg;

  localparam int AW = 5;
  localparam int DW = 32;

  typedef struct packed {
    logic [AW-1:0] dir;
    logic [DW-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/br_wb_fifo.sv
// In-order writeback FIFO: two ordered pushes, one pop.
// Entry array and valid bits are exposed for hazard compare.
module br_wb_fifo
  import br_writeback_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push_a,
  input  wb_req_t               din_a,
  input  logic                  push_b,
  input  wb_req_t               din_b,
  input  logic                  pop,
  output wb_req_t               head,
  output logic [CW-1:0]         count,
  output wb_req_t [DEPTH-1:0]   ent,
  output logic [DEPTH-1:0]      vld
);

  logic [PW-1:0] wp;
  logic [PW-1:0] rp;
  logic [PW-1:0] wp_b;

  // Second push lands behind the first when both fire.
  always_comb begin
    wp_b = wp + PW'(push_a);
    head = ent[rp];
  end

  // Pointers, occupancy, valid bits and entry storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
      vld   <= '0;
      ent   <= '0;
    end else begin
      if (pop) begin
        vld[rp] <= 1'b0;
        rp      <= rp + PW'(1);
      end
      if (push_a) begin
        ent[wp] <= din_a;
        vld[wp] <= 1'b1;
      end
      if (push_b) begin
        ent[wp_b] <= din_b;
        vld[wp_b] <= 1'b1;
      end
      wp    <= wp + PW'(push_a) + PW'(push_b);
      count <= count + CW'(push_a) + CW'(push_b)
               - CW'(pop);
    end
  end

endmodule

// File: rtl/br_writeback.sv
// Register-bank write front end: ALU/MEM arbitration,
// one write per cycle, and RAW pending flags for decode.
module br_writeback
  import br_writeback_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int AW      = br_writeback_pkg::AW,
  parameter int DW      = br_writeback_pkg::DW,
  parameter int ZERO_RO = 1,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          alu_valid,
  input  logic [AW-1:0] alu_dir,
  input  logic [DW-1:0] alu_data,
  output logic          alu_ready,
  input  logic          mem_valid,
  input  logic [AW-1:0] mem_dir,
  input  logic [DW-1:0] mem_data,
  output logic          mem_ready,
  input  logic [AW-1:0] RA1,
  input  logic [AW-1:0] RA2,
  output logic          pend1,
  output logic          pend2,
  output logic [AW-1:0] Dir,
  output logic [DW-1:0] Di,
  output logic          RegEn,
  output logic [CW-1:0] count
);

  logic [CW-1:0]      free;
  logic               mem_z;
  logic               alu_z;
  logic               push_m;
  logic               push_a;
  logic               pop;
  wb_req_t            req_m;
  wb_req_t            req_a;
  wb_req_t            head;
  wb_req_t [DEPTH-1:0] ent;
  logic [DEPTH-1:0]   vld;

  // Readies from registered occupancy; MEM wins the last slot.
  always_comb begin
    free      = CW'(DEPTH) - count;
    mem_ready = (free != '0);
    alu_ready = (free >= CW'(2))
              | ((free == CW'(1)) & ~mem_valid);
    mem_z     = (ZERO_RO != 0) && (mem_dir == '0);
    alu_z     = (ZERO_RO != 0) && (alu_dir == '0);
    push_m    = mem_valid & mem_ready & ~mem_z;
    push_a    = alu_valid & alu_ready & ~alu_z;
    pop       = (count != '0);
    req_m     = '{dir: mem_dir, data: mem_data};
    req_a     = '{dir: alu_dir, data: alu_data};
  end

  br_wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_a (push_m),
    .din_a  (req_m),
    .push_b (push_a),
    .din_b  (req_a),
    .pop    (pop),
    .head   (head),
    .count  (count),
    .ent    (ent),
    .vld    (vld)
  );

  // Bank write port: pulse RegEn for each popped entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RegEn <= 1'b0;
      Dir   <= '0;
      Di    <= '0;
    end else begin
      RegEn <= pop;
      if (pop) begin
        Dir <= head.dir;
        Di  <= head.data;
      end
    end
  end

  // RAW hazard flags over queued and issuing writes.
  always_comb begin
    pend1 = RegEn & (Dir == RA1);
    pend2 = RegEn & (Dir == RA2);
    for (int i = 0; i < DEPTH; i++) begin
      if (vld[i] && ent[i].dir == RA1) pend1 = 1'b1;
      if (vld[i] && ent[i].dir == RA2) pend2 = 1'b1;
    end
    if (ZERO_RO != 0 && RA1 == '0) pend1 = 1'b0;
    if (ZERO_RO != 0 && RA2 == '0) pend2 = 1'b0;
  end

endmodule

// File: tb/tb_br_writeback.sv
// Directed bench for br_writeback.
// Vector table plus hand sequence for async reset.
module tb_br_writeback;

  logic        clk;
  logic        rst_n;
  logic        alu_valid;
  logic [4:0]  alu_dir;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        mem_valid;
  logic [4:0]  mem_dir;
  logic [31:0] mem_data;
  logic        mem_ready;
  logic [4:0]  RA1;
  logic [4:0]  RA2;
  logic        pend1;
  logic        pend2;
  logic [4:0]  Dir;
  logic [31:0] Di;
  logic        RegEn;
  logic [2:0]  count;

  int n_chk;
  int n_fail;

  br_writeback dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .alu_valid (alu_valid),
    .alu_dir   (alu_dir),
    .alu_data  (alu_data),
    .alu_ready (alu_ready),
    .mem_valid (mem_valid),
    .mem_dir   (mem_dir),
    .mem_data  (mem_data),
    .mem_ready (mem_ready),
    .RA1       (RA1),
    .RA2       (RA2),
    .pend1     (pend1),
    .pend2     (pend2),
    .Dir       (Dir),
    .Di        (Di),
    .RegEn     (RegEn),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        av;
    logic [4:0]  ad;
    logic [31:0] adata;
    logic        mv;
    logic [4:0]  md;
    logic [31:0] mdata;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic        e_en;
    logic [4:0]  e_dir;
    logic [31:0] e_di;
    logic [2:0]  e_cnt;
    logic        e_ar;
    logic        e_mr;
    logic        e_p1;
    logic        e_p2;
  } vec_t;

  localparam int NV = 26;
  vec_t vt [NV];

  function automatic vec_t mk(
    logic av, logic [4:0] ad, logic [31:0] adata,
    logic mv, logic [4:0] md, logic [31:0] mdata,
    logic [4:0] r1, logic [4:0] r2,
    logic en, logic [4:0] dr, logic [31:0] di,
    logic [2:0] cnt, logic ar, logic mr,
    logic p1, logic p2);
    vec_t v;
    v.av = av; v.ad = ad; v.adata = adata;
    v.mv = mv; v.md = md; v.mdata = mdata;
    v.r1 = r1; v.r2 = r2;
    v.e_en = en; v.e_dir = dr; v.e_di = di;
    v.e_cnt = cnt; v.e_ar = ar; v.e_mr = mr;
    v.e_p1 = p1; v.e_p2 = p2;
    return v;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic drive(input logic av,
                       input logic [4:0] ad,
                       input logic [31:0] adata,
                       input logic mv,
                       input logic [4:0] md,
                       input logic [31:0] mdata,
                       input logic [4:0] r1,
                       input logic [4:0] r2);
    alu_valid = av; alu_dir = ad; alu_data = adata;
    mem_valid = mv; mem_dir = md; mem_data = mdata;
    RA1 = r1; RA2 = r2;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);

    // idle / single ALU write to r5
    vt[0]  = mk(0,0,0, 0,0,0, 0,0,
                0,0,0, 0,1,1,0,0);
    vt[1]  = mk(1,5,32'hDEADBEEF, 0,0,0, 5,0,
                0,0,0, 0,1,1,0,0);
    vt[2]  = mk(0,0,0, 0,0,0, 5,0,
                0,0,0, 1,1,1,1,0);
    vt[3]  = mk(0,0,0, 0,0,0, 5,0,
                1,5,32'hDEADBEEF, 0,1,1,1,0);
    vt[4]  = mk(0,0,0, 0,0,0, 5,0,
                0,5,32'hDEADBEEF, 0,1,1,0,0);
    // MEM and ALU to r3 together: MEM first
    vt[5]  = mk(1,3,32'h22, 1,3,32'h11, 3,5,
                0,5,32'hDEADBEEF, 0,1,1,0,0);
    vt[6]  = mk(0,0,0, 0,0,0, 3,5,
                0,5,32'hDEADBEEF, 2,1,1,1,0);
    vt[7]  = mk(0,0,0, 0,0,0, 3,5,
                1,3,32'h11, 1,1,1,1,0);
    vt[8]  = mk(0,0,0, 0,0,0, 3,5,
                1,3,32'h22, 0,1,1,1,0);
    vt[9]  = mk(0,0,0, 0,0,0, 3,5,
                0,3,32'h22, 0,1,1,0,0);
    // fill toward one free slot, MEM priority
    vt[10] = mk(1,2,32'hA2, 1,1,32'hA1, 4,2,
                0,3,32'h22, 0,1,1,0,0);
    vt[11] = mk(1,4,32'hA4, 1,3,32'hA3, 4,2,
                0,3,32'h22, 2,1,1,0,1);
    vt[12] = mk(1,6,32'hA6, 1,5,32'hA5, 4,2,
                1,1,32'hA1, 3,0,1,1,1);
    vt[13] = mk(1,6,32'hA6, 0,0,0, 4,2,
                1,2,32'hA2, 3,1,1,1,1);
    vt[14] = mk(0,0,0, 0,0,0, 4,6,
                1,3,32'hA3, 3,1,1,1,1);
    vt[15] = mk(0,0,0, 0,0,0, 4,6,
                1,4,32'hA4, 2,1,1,1,1);
    vt[16] = mk(0,0,0, 0,0,0, 4,6,
                1,5,32'hA5, 1,1,1,0,1);
    vt[17] = mk(0,0,0, 0,0,0, 4,6,
                1,6,32'hA6, 0,1,1,0,1);
    vt[18] = mk(0,0,0, 0,0,0, 4,6,
                0,6,32'hA6, 0,1,1,0,0);
    // writes to r0 are swallowed
    vt[19] = mk(1,0,32'h99, 0,0,0, 0,0,
                0,6,32'hA6, 0,1,1,0,0);
    vt[20] = mk(0,0,0, 1,0,32'h77, 0,0,
                0,6,32'hA6, 0,1,1,0,0);
    vt[21] = mk(0,0,0, 0,0,0, 0,0,
                0,6,32'hA6, 0,1,1,0,0);
    vt[22] = mk(1,0,32'h0, 1,7,32'h70, 7,0,
                0,6,32'hA6, 0,1,1,0,0);
    vt[23] = mk(0,0,0, 0,0,0, 7,0,
                0,6,32'hA6, 1,1,1,1,0);
    vt[24] = mk(0,0,0, 0,0,0, 7,0,
                1,7,32'h70, 0,1,1,1,0);
    vt[25] = mk(0,0,0, 0,0,0, 7,0,
                0,7,32'h70, 0,1,1,0,0);

    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vt[i].av, vt[i].ad, vt[i].adata,
            vt[i].mv, vt[i].md, vt[i].mdata,
            vt[i].r1, vt[i].r2);
      #1;
      chk($sformatf("v%0d RegEn", i), 32'(RegEn),
          32'(vt[i].e_en));
      chk($sformatf("v%0d Dir", i), 32'(Dir),
          32'(vt[i].e_dir));
      chk($sformatf("v%0d Di", i), Di, vt[i].e_di);
      chk($sformatf("v%0d count", i), 32'(count),
          32'(vt[i].e_cnt));
      chk($sformatf("v%0d alu_ready", i),
          32'(alu_ready), 32'(vt[i].e_ar));
      chk($sformatf("v%0d mem_ready", i),
          32'(mem_ready), 32'(vt[i].e_mr));
      chk($sformatf("v%0d pend1", i), 32'(pend1),
          32'(vt[i].e_p1));
      chk($sformatf("v%0d pend2", i), 32'(pend2),
          32'(vt[i].e_p2));
    end

    // async reset with three queued and one issuing
    @(negedge clk);
    drive(1, 9, 32'h90, 1, 8, 32'h80, 9, 10);
    @(negedge clk);
    drive(1, 11, 32'hB0, 1, 10, 32'hA0, 9, 10);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 9, 10);
    #1;
    chk("pre_rst RegEn", 32'(RegEn), 32'd1);
    chk("pre_rst Dir", 32'(Dir), 32'd8);
    chk("pre_rst count", 32'(count), 32'd3);
    chk("pre_rst pend1", 32'(pend1), 32'd1);
    chk("pre_rst pend2", 32'(pend2), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst RegEn", 32'(RegEn), 32'd0);
    chk("rst count", 32'(count), 32'd0);
    chk("rst pend1", 32'(pend1), 32'd0);
    chk("rst pend2", 32'(pend2), 32'd0);
    chk("rst Dir", 32'(Dir), 32'd0);
    chk("rst Di", Di, 32'd0);
    chk("rst alu_ready", 32'(alu_ready), 32'd1);
    chk("rst mem_ready", 32'(mem_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("post_rst%0d RegEn", k),
          32'(RegEn), 32'd0);
      chk($sformatf("post_rst%0d count", k),
          32'(count), 32'd0);
      chk($sformatf("post_rst%0d pend1", k),
          32'(pend1), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
